// File: rtl/axi4_stream_fifo.sv
// AXI4-Stream FIFO: ring-buffer storage behind a registered output stage; cnt includes the beat on sto.
// Optional synchronous flush port clr is enabled by defining AXI4_STREAM_FIFO_CLR_EN.
module axi4_stream_fifo #(
   parameter int DN = 1,
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic             ACLK,
   input  logic             ARESET,
`ifdef AXI4_STREAM_FIFO_CLR_EN
   input  logic             clr,
`endif
   input  logic             sti_TVALID,
   output logic             sti_TREADY,
   input  logic [DN*DW-1:0] sti_TDATA,
   input  logic [DN-1:0]    sti_TKEEP,
   input  logic             sti_TLAST,
   output logic             sto_TVALID,
   input  logic             sto_TREADY,
   output logic [DN*DW-1:0] sto_TDATA,
   output logic [DN-1:0]    sto_TKEEP,
   output logic             sto_TLAST,
   output logic [AW:0]      cnt
);

   localparam int DEPTH = 2 ** AW;
   localparam int BW    = DN * DW + DN + 1;

   logic [BW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [AW:0]   cnt_reg, cnt_next;
   logic          out_valid_reg, out_valid_next;
   logic [BW-1:0] out_beat_reg, out_beat_next;
   logic          in_ready_reg, in_ready_next;

   logic          accept, emit, load, mem_empty, mem_wr;
   logic [AW:0]   mem_cnt;
   logic [BW-1:0] in_beat;

   assign in_beat   = {sti_TKEEP, sti_TLAST, sti_TDATA};
   assign accept    = sti_TVALID && in_ready_reg;
   assign emit      = out_valid_reg && sto_TREADY;
   // The output stage is always refilled when it is empty, so an empty output stage implies empty storage.
   assign mem_cnt   = cnt_reg - (AW+1)'(out_valid_reg);
   assign mem_empty = (mem_cnt == '0);
   assign load      = !out_valid_reg || emit;
   // A beat bypasses storage only when the output stage is being refilled and storage has nothing older.
   assign mem_wr    = accept && !(load && mem_empty);

   always_comb begin
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      out_valid_next = out_valid_reg;
      out_beat_next  = out_beat_reg;
      cnt_next       = cnt_reg + (AW+1)'(accept) - (AW+1)'(emit);
      if (mem_wr) begin
         wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (load) begin
         if (!mem_empty) begin
            out_beat_next  = mem[rd_ptr_reg];
            rd_ptr_next    = rd_ptr_reg + 1'b1;
            out_valid_next = 1'b1;
         end else if (accept) begin
            out_beat_next  = in_beat;
            out_valid_next = 1'b1;
         end else begin
            out_valid_next = 1'b0;
         end
      end
      in_ready_next = (cnt_next != (AW+1)'(DEPTH));
`ifdef AXI4_STREAM_FIFO_CLR_EN
      if (clr) begin
         wr_ptr_next    = '0;
         rd_ptr_next    = '0;
         cnt_next       = '0;
         out_valid_next = 1'b0;
         in_ready_next  = 1'b1;
      end
`endif
   end

   always_ff @(posedge ACLK) begin
      if (mem_wr) begin
         mem[wr_ptr_reg] <= in_beat;
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_beat_reg  <= '0;
         in_ready_reg  <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         cnt_reg       <= cnt_next;
         out_valid_reg <= out_valid_next;
         out_beat_reg  <= out_beat_next;
         in_ready_reg  <= in_ready_next;
      end
   end

   assign sti_TREADY = in_ready_reg;
   assign sto_TVALID = out_valid_reg;
   assign sto_TDATA  = out_beat_reg[DN*DW-1:0];
   assign sto_TLAST  = out_beat_reg[DN*DW];
   assign sto_TKEEP  = out_beat_reg[BW-1 -: DN];
   assign cnt        = cnt_reg;

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Directed and random-backpressure bench for axi4_stream_fifo with AW=2 (four beats).
// Exercises the clr flush as well when AXI4_STREAM_FIFO_CLR_EN is defined.
module tb_axi4_stream_fifo;

   localparam int DN = 1;
   localparam int DW = 8;
   localparam int AW = 2;

   logic             ACLK = 1'b0;
   logic             ARESET;
   logic             sti_TVALID, sti_TREADY, sti_TLAST;
   logic [DN*DW-1:0] sti_TDATA;
   logic [DN-1:0]    sti_TKEEP;
   logic             sto_TVALID, sto_TREADY, sto_TLAST;
   logic [DN*DW-1:0] sto_TDATA;
   logic [DN-1:0]    sto_TKEEP;
   logic [AW:0]      cnt;
`ifdef AXI4_STREAM_FIFO_CLR_EN
   logic             clr = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   axi4_stream_fifo #(.DN(DN), .DW(DW), .AW(AW)) dut (
      .ACLK(ACLK),
      .ARESET(ARESET),
`ifdef AXI4_STREAM_FIFO_CLR_EN
      .clr(clr),
`endif
      .sti_TVALID(sti_TVALID),
      .sti_TREADY(sti_TREADY),
      .sti_TDATA(sti_TDATA),
      .sti_TKEEP(sti_TKEEP),
      .sti_TLAST(sti_TLAST),
      .sto_TVALID(sto_TVALID),
      .sto_TREADY(sto_TREADY),
      .sto_TDATA(sto_TDATA),
      .sto_TKEEP(sto_TKEEP),
      .sto_TLAST(sto_TLAST),
      .cnt(cnt)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Sideband is derived from the data so order errors also show up on TLAST/TKEEP.
   task automatic drive(input logic [7:0] d);
      sti_TDATA = d;
      sti_TLAST = d[0];
      sti_TKEEP = d[1];
   endtask

   initial begin
      logic [9:0] q[$];
      logic [9:0] front;
      logic [7:0] nd;
      int sent, recv, cyc;

      ARESET = 1'b1;
      sti_TVALID = 1'b0;
      sto_TREADY = 1'b0;
      sti_TDATA = '0;
      sti_TKEEP = '0;
      sti_TLAST = 1'b0;
      tick();
      check("rst_cnt", 32'(cnt), 0);
      check("rst_sto_valid", 32'(sto_TVALID), 0);
      check("rst_sti_ready", 32'(sti_TREADY), 0);
      check("rst_sto_beat", 32'({sto_TKEEP, sto_TLAST, sto_TDATA}), 0);
      ARESET = 1'b0;
      tick();
      check("rst_ready_rise", 32'(sti_TREADY), 1);

      // single beat
      sti_TVALID = 1'b1;
      sti_TDATA = 8'h5A;
      sti_TLAST = 1'b1;
      sti_TKEEP = 1'b1;
      tick();
      sti_TVALID = 1'b0;
      check("single_valid", 32'(sto_TVALID), 1);
      check("single_data", 32'(sto_TDATA), 32'h5A);
      check("single_last", 32'(sto_TLAST), 1);
      check("single_cnt", 32'(cnt), 1);
      sto_TREADY = 1'b1;
      tick();
      check("single_cnt_after", 32'(cnt), 0);
      check("single_valid_after", 32'(sto_TVALID), 0);
      sto_TREADY = 1'b0;
      $display("phase single beat done");

      // fill with downstream stalled
      sti_TVALID = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         drive(8'(v));
         tick();
         check("fill_cnt", 32'(cnt), 32'(v));
      end
      check("fill_ready_low", 32'(sti_TREADY), 0);
      drive(8'h05);
      tick();
      check("fill_cnt_held", 32'(cnt), 4);
      check("fill_head", 32'(sto_TDATA), 32'h01);
      check("fill_stable_valid", 32'(sto_TVALID), 1);

      // full plus a single emit
      sto_TREADY = 1'b1;
      tick();
      sto_TREADY = 1'b0;
      check("fe_cnt", 32'(cnt), 3);
      check("fe_ready", 32'(sti_TREADY), 1);
      check("fe_head", 32'(sto_TDATA), 32'h02);
      tick();
      sti_TVALID = 1'b0;
      check("fe_cnt_refill", 32'(cnt), 4);
      check("fe_ready_low", 32'(sti_TREADY), 0);
      sto_TREADY = 1'b1;
      for (int v = 2; v <= 5; v++) begin
         check("fe_order_valid", 32'(sto_TVALID), 1);
         check("fe_order_data", 32'(sto_TDATA), 32'(v));
         tick();
      end
      check("fe_drained_cnt", 32'(cnt), 0);
      check("fe_drained_valid", 32'(sto_TVALID), 0);
      sto_TREADY = 1'b0;
      $display("phase fill and full-plus-emit done");

      // streaming at cnt=2 so the storage pointers advance and wrap
      sti_TVALID = 1'b1;
      drive(8'h10);
      tick();
      drive(8'h11);
      tick();
      check("stream_pre_cnt", 32'(cnt), 2);
      sto_TREADY = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         drive(8'(8'h11 + k));
         tick();
         check("stream_data", 32'(sto_TDATA), 32'(8'h10 + k));
         check("stream_last", 32'(sto_TLAST), 32'(k % 2));
         check("stream_cnt", 32'(cnt), 2);
         check("stream_ready", 32'(sti_TREADY), 1);
      end
      sti_TVALID = 1'b0;
      tick();
      check("stream_tail_data", 32'(sto_TDATA), 32'h25);
      check("stream_tail_cnt", 32'(cnt), 1);
      tick();
      check("stream_empty_cnt", 32'(cnt), 0);
      sto_TREADY = 1'b0;
      $display("phase streaming done");

      // random backpressure against a queue model
      sent = 0;
      recv = 0;
      cyc = 0;
      nd = 8'h00;
      while (recv < 1000 && cyc < 20000) begin
         sti_TVALID = (sent < 1000) && ($urandom_range(0, 3) != 0);
         drive(nd);
         sto_TREADY = ($urandom_range(0, 2) != 0);
         if (sto_TVALID && sto_TREADY) begin
            if (q.size() == 0) begin
               check("rand_unexpected_beat", 32'(sto_TVALID), 0);
            end else begin
               front = q.pop_front();
               check("rand_beat", 32'({sto_TKEEP, sto_TLAST, sto_TDATA}), 32'(front));
            end
            recv++;
         end
         if (sti_TVALID && sti_TREADY) begin
            q.push_back({sti_TKEEP, sti_TLAST, sti_TDATA});
            sent++;
            nd = nd + 8'h01;
         end
         tick();
         cyc++;
         check("rand_cnt", 32'(cnt), 32'(q.size()));
         check("rand_cnt_bound", 32'(cnt <= 3'd4), 1);
      end
      check("rand_received", 32'(recv), 1000);
      sti_TVALID = 1'b0;
      sto_TREADY = 1'b0;
      $display("phase random backpressure done: %0d beats in %0d cycles", recv, cyc);

      // reset mid-operation
      sti_TVALID = 1'b1;
      for (int v = 0; v < 3; v++) begin
         drive(8'(8'hA0 + v));
         tick();
      end
      sti_TVALID = 1'b0;
      check("mrst_pre_cnt", 32'(cnt), 3);
      #1;
      ARESET = 1'b1;
      #1;
      check("mrst_valid", 32'(sto_TVALID), 0);
      check("mrst_cnt", 32'(cnt), 0);
      check("mrst_ready", 32'(sti_TREADY), 0);
      #1;
      ARESET = 1'b0;
      sto_TREADY = 1'b1;
      tick();
      check("mrst_ready_rise", 32'(sti_TREADY), 1);
      check("mrst_no_beat", 32'(sto_TVALID), 0);
      check("mrst_cnt_after", 32'(cnt), 0);
      sto_TREADY = 1'b0;
      $display("phase mid-operation reset done");

`ifdef AXI4_STREAM_FIFO_CLR_EN
      sti_TVALID = 1'b1;
      drive(8'h61);
      tick();
      drive(8'h62);
      tick();
      check("clr_pre_cnt", 32'(cnt), 2);
      drive(8'h77);
      clr = 1'b1;
      sto_TREADY = 1'b1;
      tick();
      clr = 1'b0;
      sti_TVALID = 1'b0;
      check("clr_cnt", 32'(cnt), 0);
      check("clr_valid", 32'(sto_TVALID), 0);
      check("clr_ready", 32'(sti_TREADY), 1);
      tick();
      check("clr_dropped", 32'(sto_TVALID), 0);
      sto_TREADY = 1'b0;
      $display("phase clear done");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi4_stream_fifo.md
AXI4_STREAM_FIFO -- requirements
Module: axi4_stream_fifo

Interface
REQ-001 SHALL have parameter DN, default 1: number of data lanes per beat.
REQ-002 SHALL have parameter DW, default 8: bits per lane.
REQ-003 SHALL have parameter AW, default 4: address width; capacity DEPTH = 2**AW beats.
REQ-004 SHALL have port ACLK  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET  in  1  asynchronous reset, active-high.
REQ-006 SHALL have ports sti_TVALID in 1, sti_TREADY out 1, sti_TDATA in DN*DW, sti_TKEEP in DN, sti_TLAST in 1: the upstream stream.
REQ-007 SHALL have ports sto_TVALID out 1, sto_TREADY in 1, sto_TDATA out DN*DW, sto_TKEEP out DN, sto_TLAST out 1: the downstream stream, which feeds a delay line or register stage.
REQ-008 SHALL have port cnt  out  AW+1  number of beats held, including the beat presented on sto.

Function
REQ-009 SHALL accept an input beat when sti_TVALID and sti_TREADY are both high, and emit an output beat when sto_TVALID and sto_TREADY are both high.
REQ-010 SHALL store TDATA, TKEEP and TLAST together per beat and emit beats in acceptance order, unmodified.
REQ-011 SHALL drive sti_TREADY = (cnt != DEPTH), registered, with no combinational path from sto_TREADY.
REQ-012 SHALL drive sto_TVALID = (cnt != 0) from registers; sto_TDATA, TKEEP and TLAST come from an output register.
REQ-013 SHALL have a latency of 1 cycle: a beat accepted into an empty FIFO at edge N is valid on sto after edge N and transferable at edge N+1.
REQ-014 SHALL hold sto_TDATA, TKEEP and TLAST stable while sto_TVALID is high and sto_TREADY is low.
REQ-015 SHALL, on a simultaneous accept and emit, leave cnt unchanged and keep order intact, including at cnt = 1.
REQ-016 SHALL, when full, accept no beat in that cycle even if an emit occurs in the same cycle; sti_TREADY rises the cycle after the emit.
REQ-017 SHALL, when empty, not pass input straight through in the same cycle.
REQ-018 SHALL wrap read and write pointers modulo DEPTH with no gap or duplicate at the wrap.
REQ-019 SHALL update cnt as +1 for accept only, -1 for emit only, and 0 otherwise, saturating at neither bound, because the handshake makes overflow and underflow impossible.

Reset
REQ-020 SHALL, while ARESET is high, force cnt = 0, pointers = 0, sto_TVALID = 0 and sti_TREADY = 0, asynchronously.
REQ-021 SHALL set sti_TREADY = 1 on the first edge after ARESET deasserts.
REQ-022 SHALL reset sto_TDATA, TKEEP and TLAST to 0; memory contents are not reset.
REQ-023 SHALL discard all stored beats if ARESET asserts mid-operation, with no partial beat emitted afterwards.

Configuration
REQ-024 SHALL, when macro AXI4_STREAM_FIFO_CLR_EN is defined, add port clr  in  1, a synchronous flush: at an edge with clr high, cnt, pointers and sto_TVALID go to 0, and any beat accepted or emitted in that cycle is dropped or counted as consumed. sti_TREADY stays 1.
REQ-025 SHALL, when AXI4_STREAM_FIFO_CLR_EN is undefined, have no clr port and no flush logic.

Verification
REQ-026 SHALL be verified for single beat: AW=2, write 0x5A with TLAST=1 into empty FIFO -> sto_TVALID high one cycle later, TDATA=0x5A, TLAST=1, cnt=1; after emit cnt=0.
REQ-027 SHALL be verified for fill: AW=2, sto_TREADY=0, push 0x01..0x05 continuously -> 4 accepted, sti_TREADY low after 4th, cnt=4, 0x05 held upstream.
REQ-028 SHALL be verified for full plus emit: from full, pulse sto_TREADY one cycle -> 0x01 emitted, sti_TREADY high next cycle, 0x05 accepted, order 0x02..0x05 preserved.
REQ-029 SHALL be verified for streaming: both sides ready for 20 cycles with incrementing data -> 1 beat per cycle, cnt constant, pointers wrap past 3 with no loss.
REQ-030 SHALL be verified for random backpressure: random TVALID/TREADY, 1000 beats -> output sequence equals input sequence, cnt never exceeds 4.
REQ-031 SHALL be verified for reset and clear: assert ARESET with cnt=3 -> sto_TVALID=0, cnt=0 immediately; with AXI4_STREAM_FIFO_CLR_EN, clr with cnt=2 -> cnt=0 next cycle.
